lab_pipelined_cla_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor. One GROUP-bit CLA

---
 rtl/lab_pipelined_cla_adder_if.sv | 27 ++
 rtl/lab_pipelined_cla_adder.sv | 117 +++++++++++
 tb/tb_lab_pipelined_cla_adder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lab_pipelined_cla_adder_if.sv
// rtl/lab_pipelined_cla_adder_if.sv - operand/result handshake bundle for the pipelined CLA adder
interface lab_pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/lab_pipelined_cla_adder.sv
// rtl/lab_pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage
module lab_pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lab_pipelined_cla_adder_if.slave bus
);
  localparam int               STAGES   = WIDTH / GROUP;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              stall;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [GROUP-1:0]  p [STAGES];
  logic [GROUP-1:0]  g [STAGES];
  logic [GROUP:0]    cy [STAGES];

  // Fully expanded lookahead: c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]c0.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] pp,
                                                  input logic [GROUP-1:0] gg,
                                                  input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & pp[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gg[j];
        for (int m = j + 1; m <= i; m++) term = term & pp[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  assign stall        = vld_q[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c[0] = bus.sub | bus.cin;
    src_s[0] = '0;
    src_v[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
      src_v[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      p[k]  = src_a[k][k*GROUP +: GROUP] ^ src_b[k][k*GROUP +: GROUP];
      g[k]  = src_a[k][k*GROUP +: GROUP] & src_b[k][k*GROUP +: GROUP];
      cy[k] = cla_carries(p[k], g[k], src_c[k]);
      // Consumed operand bits are zeroed so they never propagate downstream.
      a_d[k] = src_a[k] & (ALL_ONES << ((k + 1) * GROUP));
      b_d[k] = src_b[k] & (ALL_ONES << ((k + 1) * GROUP));
      s_d[k] = src_s[k];
      s_d[k][k*GROUP +: GROUP] = p[k] ^ cy[k][GROUP-1:0];
      c_d[k]   = cy[k][GROUP];
      vld_d[k] = src_v[k];
    end
    ovf_d  = cy[STAGES-1][GROUP] ^ cy[STAGES-1][GROUP-1];
    zero_d = ~|s_d[STAGES-1];
  end

  // A stall freezes every stage, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_lab_pipelined_cla_adder.sv
// tb/tb_lab_pipelined_cla_adder.sv - scoreboard bench for the pipelined CLA adder
module tb_lab_pipelined_cla_adder;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lab_pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  lab_pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t         exp_q[$];
  vec_t         tbl[10];
  int           errors    = 0;
  int           checks    = 0;
  int           cyc       = 0;
  int           first_acc = -1;
  int           first_out = -1;
  int           last_out  = -1;
  int           out_cnt   = 0;
  logic [W-1:0] held_sum;

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    vec_t         v;
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
    v.a    = a;
    v.b    = b;
    v.cin  = cin;
    v.sub  = sub;
    v.sum  = r[W-1:0];
    v.cout = r[W];
    v.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    v.zero = (r[W-1:0] == '0);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    return model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a falling edge; drives, samples 1 time unit later, then waits a cycle.
  task automatic step(input logic iv, input vec_t v, input logic ordy);
    vec_t e;
    bus.in_valid  = iv;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.cin       = v.cin;
    bus.sub       = v.sub;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sum=%h with nothing outstanding", bus.sum);
      end else begin
        e = exp_q.pop_front();
        if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf || bus.zero !== e.zero) begin
          errors++;
          $display("FAIL result a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                   e.a, e.b, e.cin, e.sub, bus.sum, bus.cout, bus.ovf, bus.zero,
                   e.sum, e.cout, e.ovf, e.zero);
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      if (first_acc < 0) first_acc = cyc;
      exp_q.push_back(v);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, rand_vec(), 1'b1);
      n++;
    end
    check("drain_outstanding", W'(exp_q.size()), '0);
  endtask

  task automatic reset_trackers();
    first_acc = -1;
    first_out = -1;
    last_out  = -1;
    out_cnt   = 0;
  endtask

  initial begin
    tbl[0] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 16'hA5A5;
    bus.b         = 16'h5A5A;
    bus.cin       = 1'b1;
    bus.sub       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", W'(bus.out_valid), '0);
    check("reset_sum", bus.sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", W'(bus.in_ready), W'(1));
    @(negedge clk);

    // Directed vectors, back to back.
    for (int i = 0; i < 10; i++) step(1'b1, tbl[i], 1'b1);
    drain(20);

    // Streaming: 8 ops, first result 4 cycles after the first accept, then contiguous.
    reset_trackers();
    for (int i = 0; i < 8; i++) step(1'b1, rand_vec(), 1'b1);
    drain(20);
    check("stream_latency", W'(first_out - first_acc), W'(4));
    check("stream_count", W'(out_cnt), W'(8));
    check("stream_contiguous", W'(last_out - first_out), W'(7));

    // Backpressure with a full pipe for 3 cycles.
    for (int i = 0; i < 4; i++) step(1'b1, rand_vec(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.out_ready = 1'b0;
      #1;
      check("stall_in_ready", W'(bus.in_ready), '0);
      check("stall_out_valid", W'(bus.out_valid), W'(1));
      if (i == 0) held_sum = bus.sum;
      else check("stall_sum_held", bus.sum, held_sum);
      cyc++;
      @(negedge clk);
    end
    drain(20);

    // Asynchronous reset while results are in flight.
    for (int i = 0; i < 6; i++) step(1'b1, rand_vec(), 1'b1);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", W'(bus.out_valid), '0);
    check("midreset_sum", bus.sum, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, rand_vec(), 1'b1);
    check("midreset_no_stale", W'(bus.out_valid), '0);

    // Random traffic with random stalls and bubbles.
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 3) != 0);
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
